// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10
    } arb_state_e;

    localparam int unsigned LAT_DEFAULT = 2;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that saturates at zero; zero flags the final access cycle.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// fixed-latency accesses, registered read data and a pipeline stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 19,
    parameter int unsigned LAT    = LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    arb_state_e        state_q, state_d;
    logic              last_dm_q, last_dm_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic cnt_load, cnt_en, cnt_zero;
    logic if_elig, dm_elig, grant_if, grant_dm;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (LAT_M1),
        .zero     (cnt_zero)
    );

    always_comb begin
        // A requester finishing this cycle may already be re-requesting; skip it once.
        if_elig  = if_req & ~if_done_q;
        dm_elig  = dm_req & ~dm_done_q;
        grant_dm = dm_elig & (~if_elig | ~last_dm_q);
        grant_if = if_elig & ~grant_dm;

        state_d    = state_q;
        last_dm_d  = last_dm_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d  = BUSY_DM;
                    cnt_load = 1'b1;
                end else if (grant_if) begin
                    state_d  = BUSY_IF;
                    cnt_load = 1'b1;
                end
            end
            BUSY_IF: begin
                if (cnt_zero) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                    last_dm_d  = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            BUSY_DM: begin
                if (cnt_zero) begin
                    state_d   = IDLE;
                    dm_done_d = 1'b1;
                    last_dm_d = 1'b1;
                    if (!dm_we) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_dm_q  <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            BUSY_IF: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            BUSY_DM: begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            default: ;
        endcase
    end

    assign if_done    = if_done_q;
    assign dm_done    = dm_done_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign pipe_stall = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 19;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          if_done, dm_done, mem_en, mem_we, pipe_stall;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem_arr [0:65535];

    int checks = 0;
    int failures = 0;

    // Model: owner 0 = none, 1 = IF, 2 = DM; m_left = busy cycles remaining incl. current.
    int            m_owner, m_left;
    bit            m_last_dm, m_if_done, m_dm_done;
    logic [DW-1:0] m_if_rdata, m_dm_rdata;

    int   en_cycles;
    bit   prev_en;
    int   grant_log [$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    assign mem_rdata = mem_arr[mem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_last_dm = 0;
        m_if_done = 0; m_dm_done = 0;
        m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    task automatic check_outputs();
        chk("mem_en",    mem_en,    32'(m_owner != 0));
        chk("mem_we",    mem_we,    32'(m_owner == 2 && dm_we));
        chk("mem_addr",  mem_addr,  m_owner == 1 ? 32'(if_addr) : m_owner == 2 ? 32'(dm_addr) : 0);
        chk("mem_wdata", mem_wdata, m_owner == 2 ? 32'(dm_wdata) : 0);
        chk("if_done",   if_done,   32'(m_if_done));
        chk("dm_done",   dm_done,   32'(m_dm_done));
        chk("if_rdata",  if_rdata,  32'(m_if_rdata));
        chk("dm_rdata",  dm_rdata,  32'(m_dm_rdata));
        chk("pipe_stall", pipe_stall,
            32'((if_req && !m_if_done) || (dm_req && !m_dm_done)));
        if (mem_en === 1'b1) begin
            en_cycles++;
            if (!prev_en) grant_log.push_back(mem_addr == dm_addr ? 2 : 1);
        end
        prev_en = (mem_en === 1'b1);
    endtask

    task automatic model_edge();
        bit ie, de, nif, ndm;
        nif = 0; ndm = 0;
        if (m_owner != 0) begin
            if (m_left == 1) begin
                if (m_owner == 1) begin
                    nif = 1; m_if_rdata = mem_arr[if_addr]; m_last_dm = 0;
                end else begin
                    ndm = 1; m_last_dm = 1;
                    if (!dm_we) m_dm_rdata = mem_arr[dm_addr];
                end
                m_owner = 0;
            end else begin
                m_left--;
            end
        end else begin
            ie = if_req && !m_if_done;
            de = dm_req && !m_dm_done;
            if (de && (!ie || !m_last_dm)) begin
                m_owner = 2; m_left = LAT;
            end else if (ie) begin
                m_owner = 1; m_left = LAT;
            end
        end
        m_if_done = nif;
        m_dm_done = ndm;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (m_owner == 2 && dm_we) mem_arr[dm_addr] = dm_wdata;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        chk("rst_mem_en",  mem_en,  0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        model_reset();
        prev_en = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = DW'($urandom);
        mem_arr[16'h0010] = 19'h1ABCD;
        model_reset();
        en_cycles = 0;
        prev_en = 0;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("idle_no_en", en_cycles, 0);

        // Single fetch
        if_req = 1'b1; if_addr = 16'h0010; en_cycles = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("fetch_done_lat", if_done, 1);
        chk("fetch_rdata", if_rdata, 19'h1ABCD);
        chk("fetch_en_cycles", en_cycles, LAT);
        chk("fetch_stall_done", pipe_stall, 0);
        if_req = 1'b0;
        tick();

        // Store then load at 0x0020
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 19'h05555;
        for (int k = 0; k < 20 && !m_dm_done; k++) tick();
        chk("store_done", dm_done, 1);
        chk("store_rdata_kept", dm_rdata, 0);
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
        tick();
        dm_req = 1'b1;
        for (int k = 0; k < 20 && !m_dm_done; k++) tick();
        chk("load_done", dm_done, 1);
        chk("load_rdata", dm_rdata, 19'h05555);
        dm_req = 1'b0;
        tick();

        // Simultaneous requests from a fresh idle: DM first, then IF
        do_reset();
        grant_log.delete();
        if_req = 1'b1; if_addr = 16'h0030;
        dm_req = 1'b1; dm_addr = 16'h0040;
        for (int k = 0; k < 20 && !m_dm_done; k++) tick();
        dm_req = 1'b0;
        for (int k = 0; k < 20 && !m_if_done; k++) tick();
        if_req = 1'b0;
        tick();
        chk("simul_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk("simul_first_dm", grant_log[0], 2);
            chk("simul_then_if", grant_log[1], 1);
        end

        // Continuous requests alternate without starving IF
        do_reset();
        grant_log.delete();
        if_req = 1'b1; dm_req = 1'b1;
        for (int k = 0; k < 40 && grant_log.size() < 4; k++) tick();
        chk("cont_grants", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            chk("cont_g0", grant_log[0], 2);
            chk("cont_g1", grant_log[1], 1);
            chk("cont_g2", grant_log[2], 2);
            chk("cont_g3", grant_log[3], 1);
        end
        if_req = 1'b0; dm_req = 1'b0;
        do_reset();

        // Reset in the second busy cycle of a fetch
        if_req = 1'b1; if_addr = 16'h0010;
        tick(); tick();
        chk("abort_busy_before", mem_en, 1);
        if_req = 1'b0;
        do_reset();
        for (int i = 0; i < 2; i++) tick();
        if_req = 1'b1; en_cycles = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("rereq_done", if_done, 1);
        chk("rereq_rdata", if_rdata, 19'h1ABCD);
        chk("rereq_en_cycles", en_cycles, LAT);
        if_req = 1'b0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (if_req) begin
                if (m_if_done) begin
                    if_req  = 1'($urandom_range(0, 1));
                    if_addr = AW'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = AW'($urandom_range(0, 15));
            end
            if (dm_req) begin
                if (m_dm_done) begin
                    dm_req   = 1'($urandom_range(0, 1));
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_addr  = AW'($urandom_range(0, 15));
                    dm_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = AW'($urandom_range(0, 15));
                dm_wdata = DW'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported unified instruction/data memory shared by the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined core. Grants one requester at a time, drives the memory port for a fixed multi-cycle access latency, returns registered read data with a one-cycle done pulse, and raises a pipeline stall while any request is outstanding. Its stall output feeds the same PC-hold / IF_ID-hold path the hazard logic drives.

## Interface
- ADDR_W, 16: memory address width.
- DATA_W, 19: memory word width, matching the instruction width.
- LAT, 2: memory access latency in cycles; legal range 1..15.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF fetch request; held high with stable if_addr until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  registered fetched word.
- dm_req  in  1  MEM-stage request; held with stable dm_addr, dm_we, dm_wdata until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_done  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  registered load data; unchanged by stores.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable; only high while mem_en is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last enabled cycle.
- pipe_stall  out  1  combinational: (if_req & ~if_done) | (dm_req & ~dm_done).

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM. A 4-bit latency counter `cnt` runs alongside.
- IDLE: arbitrate among requests, excluding any requester whose done is high this cycle.
  - Only one eligible request: grant it.
  - Both eligible: grant DM, unless the last completed grant was DM, in which case grant IF. `last_dm` is updated on each completion.
  - On grant: move to BUSY_IF or BUSY_DM and load cnt = LAT-1.
- BUSY_x:
  - mem_en = 1. mem_addr, mem_we and mem_wdata are taken from the granted requester. mem_we = dm_we in BUSY_DM and 0 in BUSY_IF.
  - If cnt ≠ 0, decrement cnt.
  - If cnt = 0: at the edge, capture mem_rdata into x_rdata (DM stores do not capture), assert x_done for one cycle, and return to IDLE.
- Outside BUSY, mem_en, mem_we, mem_addr and mem_wdata are 0.
- Reset value of every output and register is 0: state IDLE, cnt 0, last_dm 0, both done signals 0, both rdata registers 0. The memory port is idle.
- Reset asserted mid-access aborts the access. No done pulse is produced, and the requester must re-request.
- A request dropped before its done pulse is a protocol violation. The access still completes and the done pulse still fires.

## Timing
- Request sampled high at edge E while IDLE: mem_en is high for cycles E+1 .. E+LAT, x_done and x_rdata are valid in cycle E+LAT+1.
- Request-to-done latency is LAT+1 cycles. Peak throughput is one access per LAT+1 cycles.
- Back-to-back: the other requester is granted at edge E+LAT+1, so its mem_en rises at E+LAT+2.
- The finishing requester may re-request in its done cycle but is not eligible until the following IDLE cycle.
- pipe_stall deasserts in the done cycle, so the pipeline advances at the edge ending that cycle.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE=2'b00, BUSY_IF=2'b01, BUSY_DM=2'b10) and the default LAT.
- One sub-module, `mem_lat_counter`: loadable down-counter with load, enable and a zero flag, 4 bits wide.
- Top level holds the FSM, the arbitration and last_dm logic, the output muxing and the rdata registers.

## Test plan
- Reset then idle, LAT=2: all outputs are 0, mem_en stays 0, pipe_stall is 0.
- Single fetch: if_req=1, if_addr=16'h0010, memory returns 19'h1ABCD. Required: mem_en high for 2 cycles with mem_addr=16'h0010, if_done pulses 3 cycles after the request, if_rdata=19'h1ABCD, pipe_stall high until that cycle.
- Store, then load the same address 16'h0020 with data 19'h05555. Required: the store cycle shows mem_we=1, dm_done pulses with dm_rdata unchanged, and the load returns 19'h05555.
- Simultaneous if_req and dm_req from idle. Required: DM is granted first, then IF is granted at the edge after dm_done, with no overlapping mem_en.
- Continuous dm_req and if_req over 4 accesses. Required: grant order DM, IF, DM, IF (no IF starvation).
- reset asserted in the second BUSY cycle of a fetch. Required: mem_en drops immediately, no if_done pulse, and after release the re-request completes normally.
